// File: rtl/cmd_receiver.sv
// SUMP-style command byte receiver: short (1-byte) and long (opcode + 4 LSB-first
// argument bytes) commands, with an inter-byte idle timeout on long commands.
module cmd_receiver #(
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [7:0]  opcode,
    output logic [31:0] config_data,
    output logic        execute,
    output logic        timeout,
    output logic [1:0]  fsm_state
);

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_data is don't-care otherwise. rx_ready is low only in the EXEC bubble.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARGS = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shadow_op_q, shadow_op_d;
    logic [31:0] shadow_arg_q, shadow_arg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  opcode_d;
    logic [31:0] config_d;
    logic        execute_d, timeout_d, rx_ready_d;
    logic        accept;

    assign accept    = rx_valid && rx_ready;
    assign fsm_state = state_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            shadow_op_q  <= 8'h00;
            shadow_arg_q <= 32'h0;
            cnt_q        <= 2'd0;
            timer_q      <= 32'd0;
            opcode       <= 8'h00;
            config_data  <= 32'h0;
            execute      <= 1'b0;
            timeout      <= 1'b0;
            rx_ready     <= 1'b1;
        end else begin
            state_q      <= state_d;
            shadow_op_q  <= shadow_op_d;
            shadow_arg_q <= shadow_arg_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            opcode       <= opcode_d;
            config_data  <= config_d;
            execute      <= execute_d;
            timeout      <= timeout_d;
            rx_ready     <= rx_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_op_d  = shadow_op_q;
        shadow_arg_d = shadow_arg_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        opcode_d     = opcode;
        config_d     = config_data;
        execute_d    = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_op_d = rx_data;
                    if (!rx_data[7]) begin
                        shadow_arg_d = 32'h0;
                        state_d      = EXEC;
                    end else begin
                        cnt_d   = 2'd0;
                        timer_d = 32'd0;
                        state_d = ARGS;
                    end
                end
            end
            ARGS: begin
                // An accepted byte takes priority over an expiring timer.
                if (accept) begin
                    shadow_arg_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d   = cnt_q + 2'd1;
                    timer_d = 32'd0;
                    if (cnt_q == 2'd3) begin
                        state_d = EXEC;
                    end
                end else if (timer_q == TIMEOUT - 32'd1) begin
                    state_d      = IDLE;
                    timeout_d    = 1'b1;
                    shadow_op_d  = 8'h00;
                    shadow_arg_d = 32'h0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            EXEC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs load from the shadow values being written on the edge entering EXEC.
        if (state_d == EXEC) begin
            execute_d = 1'b1;
            opcode_d  = shadow_op_d;
            config_d  = shadow_arg_d;
        end
        rx_ready_d = (state_d != EXEC);
    end

endmodule
